// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter sharing one LCD_Controller command port between two requesters,
// with a post-command settle delay and a done-timeout that reports err with the ack.
module lcd_cmd_arbiter #(
    parameter int unsigned DELAY_CYCLES   = 262142,
    parameter int unsigned DLY_W          = 18,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [8:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [8:0] data1,
    output logic       ack1,
    output logic       err,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_start,
    input  logic       lcd_done,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLD,
        ACK
    } state_t;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              last_grant;
    logic              grant_sel;

    // On a tie the requester that did not win last time is served.
    assign grant_sel = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            lcd_start  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            dly_cnt    <= '0;
            to_cnt     <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner               <= grant_sel;
                        {lcd_rs, lcd_data}  <= grant_sel ? data1 : data0;
                        lcd_start           <= 1'b1;
                        busy                <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    // lcd_done seen here belongs to a previous command and is ignored.
                    lcd_start <= 1'b0;
                    to_cnt    <= '0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (lcd_done) begin
                        if (DELAY_CYCLES == 0) begin
                            err   <= 1'b0;
                            ack0  <= ~owner;
                            ack1  <= owner;
                            state <= ACK;
                        end else begin
                            dly_cnt <= '0;
                            state   <= HOLD;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= ACK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (dly_cnt == DLY_LAST) begin
                        err   <= 1'b0;
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= ACK;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ACK: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    err        <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Table-driven bench for lcd_cmd_arbiter with a small LCD controller model
// (done three cycles after start, never, or driven by hand).
module tb_lcd_cmd_arbiter;

    localparam int DELAY   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [8:0] data0, data1;
    logic       ack0, ack1, err;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_start, lcd_done;
    logic       busy, owner;

    logic [1:0] done_mode;
    logic       manual_done;
    logic [2:0] sr = '0;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int exp_starts = 0;
    int exp_acks = 0;

    typedef struct {
        logic       rst_first;
        logic [1:0] mode;
        logic       req0;
        logic [8:0] data0;
        logic       req1;
        logic [8:0] data1;
        logic       exp_owner;
        logic [7:0] exp_data;
        logic       exp_rs;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[11];

    lcd_cmd_arbiter #(
        .DELAY_CYCLES(DELAY),
        .DLY_W(3),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .data0(data0),
        .ack0(ack0),
        .req1(req1),
        .data1(data1),
        .ack1(ack1),
        .err(err),
        .lcd_data(lcd_data),
        .lcd_rs(lcd_rs),
        .lcd_start(lcd_start),
        .lcd_done(lcd_done),
        .busy(busy),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Controller model: done is high in the third cycle after the start cycle.
    always @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], lcd_start};
    end
    assign lcd_done = (done_mode == 2'd0) ? sr[2] :
                      (done_mode == 2'd2) ? manual_done : 1'b0;

    always @(negedge clk) begin
        if (lcd_start) start_cnt++;
        if (ack0) ack0_cnt++;
        if (ack1) ack1_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for the ack, checks it, then checks the IDLE cycle that follows.
    task automatic finish_cmd(input string tag, input logic exp_owner, input logic [7:0] exp_data,
                              input logic exp_err, input int exp_lat);
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
        check({tag, "/ack_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "/ack_sel"}, 32'({ack1, ack0}), exp_owner ? 32'd2 : 32'd1);
            check({tag, "/ack_err"}, 32'(err), 32'(exp_err));
            check({tag, "/ack_latency"}, 32'(lat), 32'(exp_lat));
            check({tag, "/data_hold"}, 32'(lcd_data), 32'(exp_data));
        end
        exp_acks++;
        @(negedge clk);
        check({tag, "/idle_busy"}, 32'(busy), 32'd0);
        check({tag, "/idle_err"}, 32'(err), 32'd0);
        check({tag, "/idle_ack"}, 32'({ack1, ack0}), 32'd0);
    endtask

    initial begin
        bit ok;
        int a1_before;
        string tag;

        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = '0;
        data1 = '0;
        done_mode = 2'd0;
        manual_done = 1'b0;

        vecs[0]  = '{1'b0, 2'd0, 1'b1, 9'h038, 1'b0, 9'h000, 1'b0, 8'h38, 1'b0, 1'b0, 8};
        vecs[1]  = '{1'b1, 2'd0, 1'b1, 9'h080, 1'b1, 9'h141, 1'b0, 8'h80, 1'b0, 1'b0, 8};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 9'h000, 1'b1, 9'h141, 1'b1, 8'h41, 1'b1, 1'b0, 8};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 9'h001, 1'b1, 9'h102, 1'b0, 8'h01, 1'b0, 1'b0, 8};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 9'h003, 1'b1, 9'h104, 1'b1, 8'h04, 1'b1, 1'b0, 8};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 9'h005, 1'b1, 9'h106, 1'b0, 8'h05, 1'b0, 1'b0, 8};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 9'h007, 1'b1, 9'h108, 1'b1, 8'h08, 1'b1, 1'b0, 8};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 9'h009, 1'b1, 9'h10A, 1'b0, 8'h09, 1'b0, 1'b0, 8};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 9'h00B, 1'b1, 9'h10C, 1'b1, 8'h0C, 1'b1, 1'b0, 8};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 9'h000, 1'b1, 9'h155, 1'b1, 8'h55, 1'b1, 1'b1, TIMEOUT + 1};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 9'h0F0, 1'b0, 9'h000, 1'b0, 8'hF0, 1'b0, 1'b0, 8};

        // Reset values after one edge with rst high.
        @(negedge clk);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/owner", 32'(owner), 32'd1);
        check("rst/lcd_start", 32'(lcd_start), 32'd0);
        check("rst/lcd_data", 32'(lcd_data), 32'd0);
        check("rst/lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst/acks", 32'({ack1, ack0}), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rst_first) do_reset();
            done_mode = vecs[i].mode;
            req0  = vecs[i].req0;
            data0 = vecs[i].data0;
            req1  = vecs[i].req1;
            data1 = vecs[i].data1;
            wait_start(ok);
            check({tag, "/start_seen"}, 32'(ok), 32'd1);
            exp_starts++;
            check({tag, "/owner"}, 32'(owner), 32'(vecs[i].exp_owner));
            check({tag, "/lcd_data"}, 32'(lcd_data), 32'(vecs[i].exp_data));
            check({tag, "/lcd_rs"}, 32'(lcd_rs), 32'(vecs[i].exp_rs));
            finish_cmd(tag, vecs[i].exp_owner, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
            req0 = 1'b0;
            req1 = 1'b0;
            if (i == 0) check("vec0/ack1_never", 32'(ack1_cnt), 32'd0);
        end
        done_mode = 2'd0;

        // Stale done: high through ISSUE, low two cycles, then high again.
        done_mode   = 2'd2;
        manual_done = 1'b0;
        req0  = 1'b1;
        data0 = 9'h01C;
        wait_start(ok);
        check("stale/start_seen", 32'(ok), 32'd1);
        exp_starts++;
        manual_done = 1'b1;
        data0 = 9'h1FF;
        @(negedge clk);
        manual_done = 1'b0;
        @(negedge clk);
        check("stale/no_early_ack", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        manual_done = 1'b1;
        finish_cmd("stale", 1'b0, 8'h1C, 1'b0, DELAY + 1);
        manual_done = 1'b0;
        done_mode   = 2'd0;
        req0 = 1'b0;

        // Reset during HOLD: requester 1 wins (last grant was 0), then reset restores priority to 0.
        a1_before = ack1_cnt;
        req0  = 1'b1;
        data0 = 9'h033;
        req1  = 1'b1;
        data1 = 9'h1AA;
        wait_start(ok);
        check("rstmid/start_seen", 32'(ok), 32'd1);
        exp_starts++;
        check("rstmid/owner1", 32'(owner), 32'd1);
        check("rstmid/lcd_data1", 32'(lcd_data), 32'hAA);
        repeat (5) @(negedge clk);
        check("rstmid/busy_in_hold", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid/busy", 32'(busy), 32'd0);
        check("rstmid/lcd_start", 32'(lcd_start), 32'd0);
        check("rstmid/acks", 32'({ack1, ack0}), 32'd0);
        check("rstmid/owner_rst", 32'(owner), 32'd1);
        rst = 1'b0;
        wait_start(ok);
        check("rstmid/restart_seen", 32'(ok), 32'd1);
        exp_starts++;
        check("rstmid/owner0", 32'(owner), 32'd0);
        check("rstmid/lcd_data0", 32'(lcd_data), 32'h33);
        check("rstmid/lcd_rs0", 32'(lcd_rs), 32'd0);
        finish_cmd("rstmid", 1'b0, 8'h33, 1'b0, 8);
        req0 = 1'b0;
        req1 = 1'b0;
        check("rstmid/no_ack1", 32'(ack1_cnt), 32'(a1_before));

        repeat (3) @(negedge clk);
        check("total/starts", 32'(start_cnt), 32'(exp_starts));
        check("total/acks", 32'(ack0_cnt + ack1_cnt), 32'(exp_acks));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
